// File: rtl/alu_pkg.sv
//----------------------------------------------------------------------------
// alu_pkg : opcode and FSM state encodings shared by the multi-cycle ALU.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_NOT  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SRL  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_BEQZ = 4'b0110,
    ALU_BNEZ = 4'b0111,
    ALU_XOR  = 4'b1000,
    ALU_SUB  = 4'b1001,
    ALU_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
//----------------------------------------------------------------------------
// alu_mul_iter : unsigned shift-add multiplier, one multiplier bit per cycle.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic               busy;

  // The last partial product is folded in combinationally so the result is
  // ready on the same edge that retires the final bit.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = busy && (count == CNT_W'(WIDTH-1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
//----------------------------------------------------------------------------
// alu_mc : multi-cycle ALU with valid/ready handshakes and registered results.
// Optional iterative multiply enabled by defining ALU_MUL_EN.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] s,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    f,
  output logic                ovf,
  output logic                take_branch,
  output logic                zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;

  alu_state_e         state;
  alu_state_e         state_next;
  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] shamt;
  logic               overshift;
  logic [WIDTH-1:0]   f_calc;
  logic               ovf_calc;
  logic               br_calc;

`ifdef ALU_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign is_mul    = (alu_op_e'(s) == ALU_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_mul ? EXEC : DONE;
`ifdef ALU_MUL_EN
      EXEC: if (mul_done) state_next = DONE;
`endif
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_next = is_mul ? EXEC : DONE;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
  end

  assign sum       = a + b;
  assign diff      = a - b;
  assign shamt     = b[SHAMT_W-1:0];
  assign overshift = (b >= WIDTH'(WIDTH));

  always_comb begin
    f_calc   = '0;
    ovf_calc = 1'b0;
    br_calc  = 1'b0;
    case (alu_op_e'(s))
      ALU_ADD: begin
        f_calc   = sum;
        ovf_calc = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALU_NOT:  f_calc = ~b;
      ALU_AND:  f_calc = a & b;
      ALU_OR:   f_calc = a | b;
      ALU_SRL:  f_calc = overshift ? '0 : (a >> shamt);
      ALU_SLL:  f_calc = overshift ? '0 : (a << shamt);
      ALU_BEQZ: br_calc = (a == '0);
      ALU_BNEZ: br_calc = (a != '0);
      ALU_XOR:  f_calc = a ^ b;
      ALU_SUB: begin
        f_calc   = diff;
        ovf_calc = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      default: ;
    endcase
  end

  // Result registers only move on a one-cycle accept or multiply completion,
  // so a stalled DONE keeps f and flags stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f           <= '0;
      ovf         <= 1'b0;
      take_branch <= 1'b0;
      zero        <= 1'b0;
    end else if (accept && !is_mul) begin
      f           <= f_calc;
      ovf         <= ovf_calc;
      take_branch <= br_calc;
      zero        <= (f_calc == '0);
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      f           <= mul_product[WIDTH-1:0];
      ovf         <= |mul_product[2*WIDTH-1:WIDTH];
      take_branch <= 1'b0;
      zero        <= (mul_product[WIDTH-1:0] == '0);
    end
`endif
  end

endmodule

`default_nettype wire
